// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and constants for the data-memory access
// controller (mem_access_ctrl) and its alignment checker (align_check).
//   state_e      : controller FSM state encoding
//   W_BYTE/HALF/WORD : req_width / ram_width access-size codes (2 is illegal)
//   EXC_ADEL_DEF / EXC_ADES_DEF : default load / store address-error codes
package mem_access_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RDATA  = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd3;

  localparam logic [4:0] EXC_ADEL_DEF = 5'd4;
  localparam logic [4:0] EXC_ADES_DEF = 5'd5;

endpackage

// File: rtl/mem_access_ctrl_align_check.sv
// align_check: combinational natural-alignment check for a memory access.
// Ports:
//   addr  [1:0] in  : low two bits of the byte address
//   width [1:0] in  : access size code (W_BYTE / W_HALF / W_WORD; 2 is illegal)
//   mis         out : 1 when the width code is illegal or the address is not
//                     aligned to the access size
module align_check
  import mem_access_pkg::*;
(
  input  logic [1:0] addr,
  input  logic [1:0] width,
  output logic       mis
);

  logic width_bad;

  always_comb begin
    width_bad = (width != W_BYTE) && (width != W_HALF) && (width != W_WORD);
    // The size codes double as alignment masks: half checks bit 0, word
    // checks bits 1:0, byte checks nothing.
    mis = width_bad | ((width & addr) != 2'b00);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store controller between a
// valid/ready request port and a byte-addressed data RAM (1-cycle read
// latency). Flags misaligned / illegal-width accesses and RAM errors as
// address-error exceptions and reports each completion for one cycle.
//
// Parameters:
//   EXC_ADEL : exception code reported for a faulting load
//   EXC_ADES : exception code reported for a faulting store
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   req_valid / req_ready : request handshake (ready only in IDLE)
//   req_we, req_width, req_sign, req_addr, req_wdata : request fields
//   rsp_valid, rsp_rdata, rsp_exc, rsp_exccode       : completion report
//   ram_addr, ram_wea, ram_width, ram_sign, ram_din  : RAM command (from
//                                                      latched request)
//   ram_dout, ram_err     : RAM read data (next cycle) and error flag
//   badvaddr              : faulting address register, present only when
//                           MEM_ACCESS_BADVADDR_EN is defined
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter logic [4:0] EXC_ADEL = EXC_ADEL_DEF,
  parameter logic [4:0] EXC_ADES = EXC_ADES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_width,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_exc,
  output logic [4:0]  rsp_exccode,
  output logic [31:0] ram_addr,
  output logic        ram_wea,
  output logic [1:0]  ram_width,
  output logic        ram_sign,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  input  logic        ram_err
`ifdef MEM_ACCESS_BADVADDR_EN
  ,
  output logic [31:0] badvaddr
`endif
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  width_q, width_d;
  logic        sign_q, sign_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_exc_q, rsp_exc_d;
  logic [4:0]  rsp_exccode_q, rsp_exccode_d;
`ifdef MEM_ACCESS_BADVADDR_EN
  logic [31:0] badvaddr_q, badvaddr_d;
`endif

  logic mis;
  logic exc;

  align_check u_align_check (
    .addr  (addr_q[1:0]),
    .width (width_q),
    .mis   (mis)
  );

  assign exc = mis | ram_err;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      we_q          <= 1'b0;
      width_q       <= '0;
      sign_q        <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rsp_rdata_q   <= '0;
      rsp_exc_q     <= 1'b0;
      rsp_exccode_q <= '0;
`ifdef MEM_ACCESS_BADVADDR_EN
      badvaddr_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      width_q       <= width_d;
      sign_q        <= sign_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_exc_q     <= rsp_exc_d;
      rsp_exccode_q <= rsp_exccode_d;
`ifdef MEM_ACCESS_BADVADDR_EN
      badvaddr_q    <= badvaddr_d;
`endif
    end
  end

  // Next-state and datapath. The response fields are only written on the
  // transition into RESP, so they stay stable through ACCESS and RDATA.
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    width_d       = width_q;
    sign_d        = sign_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_exc_d     = rsp_exc_q;
    rsp_exccode_d = rsp_exccode_q;
`ifdef MEM_ACCESS_BADVADDR_EN
    badvaddr_d    = badvaddr_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          width_d = req_width;
          sign_d  = req_sign;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (we_q || exc) begin
          rsp_rdata_d   = '0;
          rsp_exc_d     = exc;
          rsp_exccode_d = exc ? (we_q ? EXC_ADES : EXC_ADEL) : 5'd0;
`ifdef MEM_ACCESS_BADVADDR_EN
          if (exc) begin
            badvaddr_d = addr_q;
          end
`endif
          state_d = S_RESP;
        end else begin
          state_d = S_RDATA;
        end
      end

      S_RDATA: begin
        rsp_rdata_d   = ram_dout;
        rsp_exc_d     = 1'b0;
        rsp_exccode_d = 5'd0;
        state_d       = S_RESP;
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs. Gating with rst_n keeps a store aborted by reset in ACCESS
  // from committing at the reset edge.
  always_comb begin
    req_ready = rst_n && (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    ram_wea   = rst_n && (state_q == S_ACCESS) && we_q && !mis;
  end

  assign ram_addr    = addr_q;
  assign ram_width   = width_q;
  assign ram_sign    = sign_q;
  assign ram_din     = wdata_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_exc     = rsp_exc_q;
  assign rsp_exccode = rsp_exccode_q;
`ifdef MEM_ACCESS_BADVADDR_EN
  assign badvaddr    = badvaddr_q;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed bench for mem_access_ctrl with a little-endian
// 256-byte RAM model (1-cycle read latency, ram_err above 0xFF).
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_width;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_exc;
  logic [4:0]  rsp_exccode;
  logic [31:0] ram_addr;
  logic        ram_wea;
  logic [1:0]  ram_width;
  logic        ram_sign;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        ram_err;
`ifdef MEM_ACCESS_BADVADDR_EN
  logic [31:0] badvaddr;
`endif

  always #5 clk = ~clk;

  mem_access_ctrl #(.EXC_ADEL(5'd4), .EXC_ADES(5'd5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_width   (req_width),
    .req_sign    (req_sign),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_exc     (rsp_exc),
    .rsp_exccode (rsp_exccode),
    .ram_addr    (ram_addr),
    .ram_wea     (ram_wea),
    .ram_width   (ram_width),
    .ram_sign    (ram_sign),
    .ram_din     (ram_din),
    .ram_dout    (ram_dout),
    .ram_err     (ram_err)
`ifdef MEM_ACCESS_BADVADDR_EN
    ,
    .badvaddr    (badvaddr)
`endif
  );

  // RAM model
  logic [7:0] mem [0:255];

  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [1:0] w, input logic s);
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[a[7:0]];
    b1 = mem[a[7:0] + 8'd1];
    b2 = mem[a[7:0] + 8'd2];
    b3 = mem[a[7:0] + 8'd3];
    case (w)
      2'd0:    mem_rd = s ? {{24{b0[7]}}, b0} : {24'h0, b0};
      2'd1:    mem_rd = s ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
      default: mem_rd = {b3, b2, b1, b0};
    endcase
  endfunction

  assign ram_err = (ram_addr > 32'h0000_00FF);

  always @(posedge clk) begin
    ram_dout <= mem_rd(ram_addr, ram_width, ram_sign);
    if (ram_wea && !ram_err) begin
      mem[ram_addr[7:0]] <= ram_din[7:0];
      if (ram_width != 2'd0) mem[ram_addr[7:0] + 8'd1] <= ram_din[15:8];
      if (ram_width == 2'd3) begin
        mem[ram_addr[7:0] + 8'd2] <= ram_din[23:16];
        mem[ram_addr[7:0] + 8'd3] <= ram_din[31:24];
      end
    end
  end

  // Event monitor
  int unsigned cyc = 0, hs_cnt = 0, rsp_cnt = 0, wea_cnt = 0;
  int unsigned hs_last = 0, hs_prev = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_valid && req_ready) begin
      hs_cnt  <= hs_cnt + 1;
      hs_prev <= hs_last;
      hs_last <= cyc;
    end
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (ram_wea)   wea_cnt <= wea_cnt + 1;
  end

  int unsigned n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  // One transaction; lat is the edge count from the handshake edge to the
  // edge at which rsp_valid is first seen high.
  task automatic xact(input logic we, input logic [1:0] w, input logic s,
                      input logic [31:0] a, input logic [31:0] wd,
                      output int lat, output logic [31:0] rd, output logic ex,
                      output logic [4:0] code, output int unsigned weas);
    int unsigned w0;
    int n;
    @(negedge clk);
    req_we = we; req_width = w; req_sign = s; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    w0 = wea_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    rd = 'x; ex = 1'bx; code = 'x;
    while (lat < 12) begin
      @(negedge clk);
      if (rsp_valid) break;
      @(posedge clk);
      lat++;
    end
    if (lat >= 12) lat = -1;
    rd = rsp_rdata; ex = rsp_exc; code = rsp_exccode;
    @(posedge clk); #1;
    weas = wea_cnt - w0;
  endtask

  int lat;
  logic [31:0] rd;
  logic ex;
  logic [4:0] code;
  int unsigned weas, r0, h0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_width = 2'd0;
    req_sign = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_low", {31'b0, req_ready}, 32'd0);
    check("rst_wea_low", {31'b0, ram_wea}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_exc", {27'b0, rsp_exccode} | {31'b0, rsp_exc}, 32'd0);
    check("rst_ready_idle", {31'b0, req_ready}, 32'd1);

    // Store word
    xact(1'b1, 2'd3, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, ex, code, weas);
    check("sw_lat", lat, 32'd2);
    check("sw_exc", {31'b0, ex}, 32'd0);
    check("sw_rdata", rd, 32'd0);
    check("sw_wea_cnt", weas, 32'd1);
    check("sw_mem", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hDEADBEEF);

    // Loads after store of 0x80FF0011
    xact(1'b1, 2'd3, 1'b0, 32'h10, 32'h80FF0011, lat, rd, ex, code, weas);
    xact(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, lat, rd, ex, code, weas);
    check("lb_lat", lat, 32'd3);
    check("lb_rdata", rd, 32'hFFFFFF80);
    check("lb_code", {27'b0, code}, 32'd0);
    check("lb_wea_cnt", weas, 32'd0);
    xact(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, lat, rd, ex, code, weas);
    check("lbu_rdata", rd, 32'h000000FF);
    xact(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, lat, rd, ex, code, weas);
    check("lh_rdata", rd, 32'hFFFF80FF);
    xact(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, lat, rd, ex, code, weas);
    check("lw_rdata", rd, 32'h80FF0011);
    check("lw_exc", {31'b0, ex}, 32'd0);

    // Misaligned accesses
    xact(1'b1, 2'd3, 1'b0, 32'h20, 32'hCAFEF00D, lat, rd, ex, code, weas);
    xact(1'b0, 2'd1, 1'b1, 32'h21, 32'h0, lat, rd, ex, code, weas);
    check("lh_mis_lat", lat, 32'd2);
    check("lh_mis_exc", {31'b0, ex}, 32'd1);
    check("lh_mis_code", {27'b0, code}, 32'd4);
    check("lh_mis_rdata", rd, 32'd0);
`ifdef MEM_ACCESS_BADVADDR_EN
    check("badvaddr_21", badvaddr, 32'h21);
`endif
    xact(1'b1, 2'd3, 1'b0, 32'h22, 32'h55555555, lat, rd, ex, code, weas);
    check("sw_mis_exc", {31'b0, ex}, 32'd1);
    check("sw_mis_code", {27'b0, code}, 32'd5);
    check("sw_mis_wea_cnt", weas, 32'd0);
    check("sw_mis_rdata", rd, 32'd0);
    xact(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, lat, rd, ex, code, weas);
    check("sw_mis_mem", rd, 32'hCAFEF00D);
    check("after_exc_code", {27'b0, code}, 32'd0);

    // Illegal width
    xact(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, lat, rd, ex, code, weas);
    check("w2_exc", {31'b0, ex}, 32'd1);
    check("w2_code", {27'b0, code}, 32'd4);
`ifdef MEM_ACCESS_BADVADDR_EN
    check("badvaddr_0", badvaddr, 32'h0);
`endif

    // RAM error
    xact(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, lat, rd, ex, code, weas);
    check("err_lat", lat, 32'd2);
    check("err_exc", {31'b0, ex}, 32'd1);
    check("err_code", {27'b0, code}, 32'd4);

    // Reset during ACCESS of a store
    xact(1'b1, 2'd3, 1'b0, 32'h30, 32'h11223344, lat, rd, ex, code, weas);
    @(negedge clk);
    req_we = 1'b1; req_width = 2'd3; req_sign = 1'b0; req_addr = 32'h30;
    req_wdata = 32'h12345678; req_valid = 1'b1;
    r0 = rsp_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("abort_wea_in_access", {31'b0, ram_wea}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_wea_gated", {31'b0, ram_wea}, 32'd0);
    check("abort_ready_low", {31'b0, req_ready}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_rsp", rsp_cnt - r0, 32'd0);
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    xact(1'b0, 2'd3, 1'b0, 32'h30, 32'h0, lat, rd, ex, code, weas);
    check("abort_old_value", rd, 32'h11223344);

    // req_valid held high across a load
    @(negedge clk);
    req_we = 1'b0; req_width = 2'd3; req_sign = 1'b0; req_addr = 32'h10;
    req_wdata = '0; req_valid = 1'b1;
    r0 = rsp_cnt; h0 = hs_cnt;
    repeat (5) @(posedge clk);
    #1 req_valid = 1'b0;
    check("hold_one_rsp", rsp_cnt - r0, 32'd1);
    check("hold_hs_cnt", hs_cnt - h0, 32'd2);
    check("hold_hs_gap", hs_last - hs_prev, 32'd4);
    repeat (4) @(posedge clk);
    #1;
    check("hold_total_rsp", rsp_cnt - r0, 32'd2);
    check("hold_rdata", rsp_rdata, 32'h80FF0011);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", n_chk, 32'd0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter EXC_ADEL, default 5'd4, exception code for load address error.
REQ-002 SHALL have parameter EXC_ADES, default 5'd5, exception code for store address error.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have ports req_valid in 1 and req_ready out 1: request handshake; a transfer occurs when both are 1 at a clock edge.
REQ-006 SHALL have req_we in 1 (1 = store), req_width in 2 (0 = byte, 1 = half, 3 = word, 2 = illegal), req_sign in 1 (load sign-extend), req_addr in 32 (byte address) and req_wdata in 32 (store data, right-aligned).
REQ-007 SHALL have rsp_valid out 1, rsp_rdata out 32, rsp_exc out 1 and rsp_exccode out 5: the completion report.
REQ-008 SHALL have ram_addr out 32, ram_wea out 1, ram_width out 2, ram_sign out 1, ram_din out 32, ram_dout in 32 and ram_err in 1: the byte-addressed data-RAM port. RAM read data is valid one cycle after the address is presented; RAM writes commit at the edge ending the cycle in which wea is 1.

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS, RDATA and RESP.
REQ-010 IDLE: req_ready is 1 only in IDLE; on a handshake, latch all req_* fields and go to ACCESS.
REQ-011 Every ram_* output SHALL be driven from the latched fields in all states, except ram_wea.
REQ-012 Local misalignment flag: mis = (width==2) | ((width & addr[1:0]) != 0).
REQ-013 ACCESS: ram_wea = we & ~mis; go to RESP on a store or on mis|ram_err, otherwise go to RDATA.
REQ-014 RDATA: ram_wea = 0; capture ram_dout into rsp_rdata at the end of the cycle; go to RESP.
REQ-015 RESP: rsp_valid = 1 for exactly one cycle, then go to IDLE; there is no response backpressure.
REQ-016 Latency: a store responds 2 cycles after the handshake edge; a load responds 3 cycles after it; an exception responds 2 cycles after it.
REQ-017 Exception: rsp_exc = mis | ram_err, sampled in ACCESS; rsp_exccode = EXC_ADES if we, else EXC_ADEL; rsp_exccode = 0 when there is no exception.
REQ-018 On an exception, no RAM write SHALL occur and rsp_rdata SHALL be 0.
REQ-019 On a store, rsp_rdata SHALL be 0.
REQ-020 Outside RESP, rsp_valid SHALL be 0; rsp_rdata, rsp_exc and rsp_exccode hold their last values.
REQ-021 ram_wea SHALL be 1 only in ACCESS.
REQ-022 req_valid asserted while the block is not in IDLE SHALL be ignored (not latched).

Reset
REQ-023 On rst_n = 0 at a clock edge: state = IDLE, all latched fields = 0, rsp_valid = 0, rsp_rdata = 0, rsp_exc = 0, rsp_exccode = 0.
REQ-024 While rst_n is low: ram_wea = 0 and req_ready = 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation without a response; a store aborted in ACCESS SHALL NOT commit.

Configuration
REQ-026 Macro MEM_ACCESS_BADVADDR_EN SHALL control the bad-address register.
REQ-027 With MEM_ACCESS_BADVADDR_EN defined: output port badvaddr (32 bits) exists, loads the latched address at the end of an ACCESS cycle that flags an exception, otherwise holds its value, and resets to 0.
REQ-028 Without MEM_ACCESS_BADVADDR_EN: the port and the register are absent; all other behaviour is identical.

Structure
REQ-029 Package mem_access_pkg SHALL hold the FSM state typedef, width codes (W_BYTE = 0, W_HALF = 1, W_WORD = 3) and the default exception codes.
REQ-030 One combinational sub-module, align_check (inputs addr[1:0] and width; output mis), SHALL be used.

Verification
REQ-031 Store: addr 0x10, width 3, wdata 0xDEADBEEF -> ram_wea = 1 for one cycle in ACCESS; rsp_valid 2 cycles after the handshake with rsp_exc = 0.
REQ-032 Load: LB with sign = 1 at 0x13 after a store of 0x80FF0011 to 0x10 -> rsp_rdata = 0xFFFFFF80, 3 cycles after the handshake.
REQ-033 Misaligned: LH at 0x21 -> rsp_exc = 1, exccode 4, rdata 0; SW at 0x22 -> exccode 5, ram_wea never 1, and memory at 0x20 is unchanged.
REQ-034 Illegal width 2 at 0x0 -> exception; with the macro defined, badvaddr = 0x0.
REQ-035 Reset in ACCESS of SW 0x30 = 0x12345678 -> no response; a later LW at 0x30 returns the old value.
REQ-036 req_valid held high through an entire load -> exactly one response; the next handshake occurs only in IDLE.
